// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud-tick generator: default sizing and the
// phase-increment calculation used to set the reset-time baud rate.
package uart_pkg;

   localparam int OS_DEFAULT    = 16;
   localparam int ACC_W_DEFAULT = 24;

   // Rounded NCO increment: round(baud * os * 2^acc_w / (clk_mhz * 1e6)).
   // Evaluated at elaboration; 64-bit intermediates keep the numerator exact
   // for acc_w up to 31 at realistic baud rates.
   function automatic logic [31:0] calc_inc(input int clk_mhz,
                                            input int baud,
                                            input int os,
                                            input int acc_w);
      longint unsigned num;
      longint unsigned den;
      num = 64'(baud) * 64'(os);
      num = num << acc_w;
      den = 64'(clk_mhz) * 64'd1_000_000;
      return 32'((num + den / 64'd2) / den);
   endfunction

endpackage

// File: rtl/uart_baud_nco_if.sv
// Control/tick bundle between the UART control logic (master) and the baud
// tick generator (slave).
interface uart_baud_nco_if
   import uart_pkg::*;
   #(parameter int ACC_W = ACC_W_DEFAULT)
   ();

   logic             en;
   logic             cfg_load;
   logic [ACC_W-1:0] cfg_inc;
   logic             rx_sync;
   logic             os_tick;
   logic             tx_tick;
   logic             rx_sample_tick;

   modport master (
      output en, cfg_load, cfg_inc, rx_sync,
      input  os_tick, tx_tick, rx_sample_tick
   );

   modport slave (
      input  en, cfg_load, cfg_inc, rx_sync,
      output os_tick, tx_tick, rx_sample_tick
   );

endinterface

// File: rtl/uart_tick_div.sv
// Modulo-MOD counter of oversample ticks. clr restarts the phase and wins over
// adv; wrap flags the tick that takes the count from MOD-1 back to 0.
module uart_tick_div #(
   parameter  int MOD   = 16,
   localparam int CNT_W = $clog2(MOD)
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             clr,
   input  logic             adv,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

   // Phase counter: reset/clear to 0, otherwise step on each advance.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (adv) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
   end

   assign wrap = adv && (cnt == LAST);

endmodule

// File: rtl/uart_baud_nco.sv
// Fractional baud-tick generator. A phase accumulator adds inc every enabled
// cycle; its carry is the oversample tick. Two tick counters derive the TX
// bit tick and the RX mid-bit sample strobe, the latter re-phased by rx_sync.
module uart_baud_nco
   import uart_pkg::*;
   #(
   parameter int CLK_FRE    = 50,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = OS_DEFAULT,
   parameter int ACC_W      = ACC_W_DEFAULT
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   uart_baud_nco_if.slave bus
);

   localparam logic [31:0]      DEF_INC_FULL = calc_inc(CLK_FRE, BAUD_RATE, OVERSAMPLE, ACC_W);
   localparam logic [ACC_W-1:0] DEF_INC      = DEF_INC_FULL[ACC_W-1:0];
   localparam int               CNT_W        = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] RX_MID       = CNT_W'(OVERSAMPLE / 2 - 1);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc;
   logic [ACC_W:0]   sum;
   logic             os_tick;
   logic [CNT_W-1:0] tx_div;
   logic [CNT_W-1:0] rx_ph;
   logic             tx_wrap;
   logic             rx_wrap_unused;

   assign sum = {1'b0, acc} + {1'b0, inc};

   // Accumulator, increment register and registered carry. Reset beats a
   // load, a load beats en; a frozen generator emits no tick.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         acc     <= '0;
         inc     <= DEF_INC;
         os_tick <= 1'b0;
      end else if (bus.cfg_load) begin
         acc     <= '0;
         inc     <= bus.cfg_inc;
         os_tick <= 1'b0;
      end else if (bus.en) begin
         acc     <= sum[ACC_W-1:0];
         os_tick <= sum[ACC_W];
      end else begin
         os_tick <= 1'b0;
      end
   end

   // TX bit phase: only a reload restarts it, so RX resync never moves TX.
   // Counters advance on an emitted os_tick even if en has just dropped, so
   // a tick already seen downstream is always accounted for exactly once.
   uart_tick_div #(.MOD(OVERSAMPLE)) u_tx_div (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clr     (bus.cfg_load),
      .adv     (os_tick),
      .cnt     (tx_div),
      .wrap    (tx_wrap)
   );

   // RX sample phase: a start-bit sync forces 0 even on a tick cycle. The
   // wrap output is not needed; RX samples at the bit midpoint instead.
   uart_tick_div #(.MOD(OVERSAMPLE)) u_rx_ph (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clr     (bus.cfg_load | bus.rx_sync),
      .adv     (os_tick),
      .cnt     (rx_ph),
      .wrap    (rx_wrap_unused)
   );

   assign bus.os_tick        = os_tick;
   assign bus.tx_tick        = tx_wrap;
   assign bus.rx_sample_tick = os_tick && (rx_ph == RX_MID);

endmodule
